reg8_access_arbiter: RTL and testbench

- Round-robin arbiter and write sequencer that shares one external 8-bit register (`register_8bit` instance, loads `in` on every clock) among N requesters.
- Drives the register's D input: the selected write data during a granted write cycle, otherwise the register's current Q (hold).
- Each access uses a req/ack handshake; all requesters see read data.

---
 rtl/reg8_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 35 +++
 rtl/reg8_access_arbiter.sv | 104 ++++++++++
 tb/tb_reg8_access_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg8_arb_pkg.sv
// Shared definitions for the 8-bit register access arbiter.
// Holds the FSM state encoding and the default data width.
package reg8_arb_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// starting just above the last winner, wrapping around.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDXW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDXW-1:0]  last,
  output logic [N_REQ-1:0] winner_oh,
  output logic [IDXW-1:0]  winner_idx,
  output logic             valid
);

  int              cand;
  logic [IDXW-1:0] cand_idx;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    // The loop visits last+1 .. last+N_REQ, so the previous winner is checked last.
    for (int k = 1; k <= N_REQ; k++) begin
      cand     = (int'(last) + k) % N_REQ;
      cand_idx = IDXW'(cand);
      if (!valid && req[cand_idx]) begin
        valid               = 1'b1;
        winner_idx          = cand_idx;
        winner_oh[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg8_access_arbiter.sv
// Round-robin arbiter and write sequencer sharing one external 8-bit register
// among N_REQ requesters through a req/ack handshake.
module reg8_access_arbiter
  import reg8_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0]       reg_q,
  output logic [WIDTH-1:0]       reg_d,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       rdata,
  output logic                   busy
);

  localparam int IDXW = $clog2(N_REQ);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  win, win_nxt;
  logic [N_REQ-1:0] win_oh, win_oh_nxt;
  logic [IDXW-1:0]  last, last_nxt;

  logic [N_REQ-1:0] pick_oh;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_valid;
  logic [WIDTH-1:0] win_wdata;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_pick (
    .req        (req),
    .last       (last),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  assign win_wdata = wdata[int'(win)*WIDTH +: WIDTH];
  assign rdata     = reg_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      win    <= '0;
      win_oh <= '0;
      last   <= IDXW'(N_REQ - 1);
    end else begin
      state  <= state_nxt;
      win    <= win_nxt;
      win_oh <= win_oh_nxt;
      last   <= last_nxt;
    end
  end

  // The register reloads every clock, so reg_d must echo reg_q whenever no write is due.
  always_comb begin
    state_nxt  = state;
    win_nxt    = win;
    win_oh_nxt = win_oh;
    last_nxt   = last;
    gnt        = '0;
    ack        = '0;
    busy       = 1'b0;
    reg_d      = reg_q;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          win_nxt    = pick_idx;
          win_oh_nxt = pick_oh;
          state_nxt  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        gnt  = win_oh;
        if (req[win]) begin
          if (we[win]) begin
            reg_d = win_wdata;
          end
          state_nxt = ST_ACK;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK: begin
        busy      = 1'b1;
        ack       = win_oh;
        last_nxt  = win;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg8_access_arbiter.sv
// Directed testbench for reg8_access_arbiter with a behavioural model of the
// shared register that reloads reg_d every clock and clears on reset.
module tb_reg8_access_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [7:0]  reg_q;
  logic [7:0]  reg_d;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        busy;

  int tests;
  int failed;

  reg8_access_arbiter #(
    .N_REQ (4),
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .wdata (wdata),
    .reg_q (reg_q),
    .reg_d (reg_d),
    .gnt   (gnt),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reg_q <= 8'h00;
    else      reg_q <= reg_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w);
    req = r;
    we  = w;
    #1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    req    = '0;
    we     = '0;
    wdata  = '0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_gnt",   32'(gnt),   32'h0);
    checkOutput("reset_ack",   32'(ack),   32'h0);
    checkOutput("reset_busy",  32'(busy),  32'h0);
    checkOutput("reset_reg_d", 32'(reg_d), 32'h00);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("idle_reg_q", 32'(reg_q), 32'h00);
    checkOutput("idle_busy",  32'(busy),  32'h0);

    // Single write by requester 2
    wdata[23:16] = 8'hA5;
    applyStimulus(4'b0100, 4'b0100);
    checkOutput("wr_pre_gnt", 32'(gnt), 32'h0);
    tick();
    checkOutput("wr_gnt",   32'(gnt),   32'h4);
    checkOutput("wr_reg_d", 32'(reg_d), 32'hA5);
    checkOutput("wr_busy",  32'(busy),  32'h1);
    tick();
    checkOutput("wr_ack",   32'(ack),   32'h4);
    checkOutput("wr_gnt0",  32'(gnt),   32'h0);
    checkOutput("wr_rdata", 32'(rdata), 32'hA5);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    checkOutput("wr_idle", 32'(busy), 32'h0);
    checkOutput("wr_ack0", 32'(ack),  32'h0);

    // Load 3C via requester 1, then re-request as a read with junk wdata
    wdata[15:8] = 8'h3C;
    applyStimulus(4'b0010, 4'b0010);
    tick();
    checkOutput("ld_gnt", 32'(gnt), 32'h2);
    tick();
    checkOutput("ld_ack", 32'(ack), 32'h2);
    wdata[15:8] = 8'hFF;
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("rd_idle",  32'(busy),  32'h0);
    checkOutput("rd_reg_d0", 32'(reg_d), 32'h3C);
    tick();
    checkOutput("rd_gnt",   32'(gnt),   32'h2);
    checkOutput("rd_reg_d", 32'(reg_d), 32'h3C);
    tick();
    checkOutput("rd_ack",   32'(ack),   32'h2);
    checkOutput("rd_rdata", 32'(rdata), 32'h3C);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Read by requester 3 leaves the pointer at 3
    applyStimulus(4'b1000, 4'b0000);
    tick();
    checkOutput("r3_gnt", 32'(gnt), 32'h8);
    tick();
    checkOutput("r3_ack",   32'(ack),   32'h8);
    checkOutput("r3_rdata", 32'(rdata), 32'h3C);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Fairness: all four requesting continuously
    wdata = {8'h13, 8'h12, 8'h11, 8'h10};
    applyStimulus(4'b1111, 4'b1111);
    for (int p = 0; p < 5; p++) begin
      tick();
      checkOutput($sformatf("rr_gnt%0d", p), 32'(gnt), 32'(1) << order[p]);
      tick();
      checkOutput($sformatf("rr_ack%0d", p),  32'(ack),   32'(1) << order[p]);
      checkOutput($sformatf("rr_reg%0d", p),  32'(reg_q), 32'h10 + 32'(order[p]));
      tick();
      checkOutput($sformatf("rr_idle%0d", p), 32'(busy), 32'h0);
    end
    applyStimulus(4'b0000, 4'b0000);

    // Requester 3 writes 11, pointer becomes 3
    wdata[31:24] = 8'h11;
    applyStimulus(4'b1000, 4'b1000);
    tick();
    tick();
    checkOutput("w11_ack", 32'(ack),   32'h8);
    checkOutput("w11_reg", 32'(reg_q), 32'h11);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Withdrawal during BUSY
    wdata[31:24] = 8'h77;
    applyStimulus(4'b1000, 4'b1000);
    tick();
    checkOutput("wd_gnt",   32'(gnt),   32'h8);
    checkOutput("wd_reg_d", 32'(reg_d), 32'h77);
    applyStimulus(4'b0000, 4'b1000);
    checkOutput("wd_hold", 32'(reg_d), 32'h11);
    tick();
    checkOutput("wd_ack",  32'(ack),   32'h0);
    checkOutput("wd_busy", 32'(busy),  32'h0);
    checkOutput("wd_reg",  32'(reg_q), 32'h11);
    applyStimulus(4'b1001, 4'b0000);
    tick();
    checkOutput("wd_next_gnt", 32'(gnt), 32'h1);
    tick();
    checkOutput("wd_next_ack",   32'(ack),   32'h1);
    checkOutput("wd_next_rdata", 32'(rdata), 32'h11);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    // Reset while requester 1 is in BUSY
    wdata[15:8] = 8'h99;
    applyStimulus(4'b0010, 4'b0010);
    tick();
    checkOutput("mr_gnt", 32'(gnt), 32'h2);
    #2 rst = 1'b0;
    #1;
    checkOutput("mr_gnt0", 32'(gnt),  32'h0);
    checkOutput("mr_ack0", 32'(ack),  32'h0);
    checkOutput("mr_busy", 32'(busy), 32'h0);
    applyStimulus(4'b0000, 4'b0000);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("mr_noack%0d", i), 32'(ack), 32'h0);
    end
    checkOutput("mr_reg", 32'(reg_q), 32'h00);
    applyStimulus(4'b0010, 4'b0000);
    tick();
    checkOutput("mr_re_gnt", 32'(gnt), 32'h2);
    tick();
    checkOutput("mr_re_ack",   32'(ack),   32'h2);
    checkOutput("mr_re_rdata", 32'(rdata), 32'h00);
    applyStimulus(4'b0000, 4'b0000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
